// File: rtl/order_msg_encoder.sv
// Serialises one order into nine 32-bit words. The first word appears the cycle after capture, and each word advances on valid&&ready.
// Downstream stalls hold the current word in place; o_ready is high only while idle. ORDER_MSG_ENCODER_CNT_EN enables o_msg_count.
module order_msg_encoder #(
   parameter int REG_WIDTH = 32
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_valid,
   output logic                 o_ready,
   input  logic [1:0]           i_order_type,
   input  logic [1:0]           i_stock_symbol,
   input  logic [REG_WIDTH-1:0] i_order_id,
   input  logic [REG_WIDTH-1:0] i_price,
   input  logic [REG_WIDTH-1:0] i_quantity,
   input  logic                 i_trade_type,
   input  logic [47:0]          i_curr_time,
   input  logic [15:0]          i_locate_code,
   input  logic [15:0]          i_tracking_number,
   output logic [REG_WIDTH-1:0] o_word,
   output logic                 o_word_valid,
   input  logic                 i_word_ready,
   output logic [3:0]           o_word_idx,
   output logic                 o_last,
   output logic                 o_err,
   output logic [15:0]          o_msg_count
);

   typedef enum logic {IDLE, SEND} state_t;

   state_t               state_q, state_d;
   logic [1:0]           type_q, sym_q;
   logic [REG_WIDTH-1:0] oid_q, price_q, qty_q;
   logic                 trade_q;
   logic [47:0]          time_q;
   logic [15:0]          loc_q, trk_q;
   logic [3:0]           idx_q;
   logic                 err_q;
   logic                 capture, beat;
   logic [63:0]          oid64, stock;
   logic [7:0]           type_byte, w4_hi;
   logic [REG_WIDTH-1:0] word_mux;

   assign capture = i_valid && o_ready;
   assign beat    = o_word_valid && i_word_ready;
   assign oid64   = {{(64-REG_WIDTH){1'b0}}, oid_q};

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (capture && i_order_type != 2'd3) state_d = SEND;
         SEND: if (beat && idx_q == 4'd8)          state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      o_ready      = (state_q == IDLE);
      o_word_valid = (state_q == SEND);
      o_word       = o_word_valid ? word_mux : '0;
      o_last       = o_word_valid && (idx_q == 4'd8);
      o_word_idx   = idx_q;
      o_err        = err_q;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         type_q  <= '0;
         sym_q   <= '0;
         oid_q   <= '0;
         price_q <= '0;
         qty_q   <= '0;
         trade_q <= 1'b0;
         time_q  <= '0;
         loc_q   <= '0;
         trk_q   <= '0;
         idx_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         err_q <= capture && (i_order_type == 2'd3);
         if (capture) begin
            type_q  <= i_order_type;
            sym_q   <= i_stock_symbol;
            oid_q   <= i_order_id;
            price_q <= i_price;
            qty_q   <= i_quantity;
            trade_q <= i_trade_type;
            time_q  <= i_curr_time;
            loc_q   <= i_locate_code;
            trk_q   <= i_tracking_number;
         end
         if (beat) idx_q <= (idx_q == 4'd8) ? 4'd0 : idx_q + 4'd1;
      end
   end

   // Stock ID is decoded from the captured symbol, so late input changes cannot leak in.
   always_comb begin
      case (sym_q)
         2'd0:    stock = 64'h4141504C20202020;
         2'd1:    stock = 64'h414D5A4E20202020;
         2'd2:    stock = 64'h474F4F474C202020;
         default: stock = 64'h4D53465420202020;
      endcase
      case (type_q)
         2'd0:    begin type_byte = 8'h41; w4_hi = {7'b0, trade_q}; end
         2'd1:    begin type_byte = 8'h58; w4_hi = stock[7:0];      end
         2'd2:    begin type_byte = 8'h45; w4_hi = qty_q[7:0];      end
         default: begin type_byte = 8'h00; w4_hi = 8'h00;           end
      endcase
   end

   always_comb begin
      word_mux = '0;
      case (idx_q)
         4'd0: word_mux = {trk_q[7:0], loc_q, type_byte};
         4'd1: word_mux = {time_q[23:0], trk_q[15:8]};
         4'd2: word_mux = {oid64[7:0], time_q[47:24]};
         4'd3: word_mux = oid64[39:8];
         4'd4: word_mux = {w4_hi, oid64[63:40]};
         4'd5: case (type_q)
                  2'd0:    word_mux = qty_q;
                  2'd1:    word_mux = stock[39:8];
                  2'd2:    word_mux = {stock[7:0], qty_q[31:8]};
                  default: word_mux = '0;
               endcase
         4'd6: case (type_q)
                  2'd0:    word_mux = stock[31:0];
                  2'd1:    word_mux = {8'h00, stock[63:40]};
                  2'd2:    word_mux = stock[39:8];
                  default: word_mux = '0;
               endcase
         4'd7: case (type_q)
                  2'd0:    word_mux = stock[63:32];
                  2'd2:    word_mux = {8'h00, stock[63:40]};
                  default: word_mux = '0;
               endcase
         4'd8: word_mux = (type_q == 2'd0) ? price_q : '0;
         default: word_mux = '0;
      endcase
   end

`ifdef ORDER_MSG_ENCODER_CNT_EN
   logic [15:0] msg_cnt_q;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)              msg_cnt_q <= '0;
      else if (o_last && beat)   msg_cnt_q <= msg_cnt_q + 16'd1;
   end

   assign o_msg_count = msg_cnt_q;
`else
   assign o_msg_count = '0;
`endif

endmodule

// File: tb/tb_order_msg_encoder.sv
// Scoreboarded bench for order_msg_encoder: directed orders, stalls, an illegal type and a mid-message reset.
module tb_order_msg_encoder;

   logic        i_clk = 1'b0;
   logic        i_rst_n = 1'b0;
   logic        i_valid = 1'b0;
   logic        o_ready;
   logic [1:0]  i_order_type = '0;
   logic [1:0]  i_stock_symbol = '0;
   logic [31:0] i_order_id = '0, i_price = '0, i_quantity = '0;
   logic        i_trade_type = 1'b0;
   logic [47:0] i_curr_time = '0;
   logic [15:0] i_locate_code = '0, i_tracking_number = '0;
   logic [31:0] o_word;
   logic        o_word_valid;
   logic        i_word_ready = 1'b1;
   logic [3:0]  o_word_idx;
   logic        o_last, o_err;
   logic [15:0] o_msg_count;

   order_msg_encoder #(.REG_WIDTH(32)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
      .i_order_type(i_order_type), .i_stock_symbol(i_stock_symbol),
      .i_order_id(i_order_id), .i_price(i_price), .i_quantity(i_quantity),
      .i_trade_type(i_trade_type), .i_curr_time(i_curr_time),
      .i_locate_code(i_locate_code), .i_tracking_number(i_tracking_number),
      .o_word(o_word), .o_word_valid(o_word_valid), .i_word_ready(i_word_ready),
      .o_word_idx(o_word_idx), .o_last(o_last), .o_err(o_err), .o_msg_count(o_msg_count)
   );

   always #5 i_clk = ~i_clk;

   int          chk_cnt = 0;
   int          pass_cnt = 0;
   int          msgs_done = 0;
   logic [36:0] exp_q[$];
   logic [31:0] wv [9];
   logic        stall_mode = 1'b0;
   logic [3:0]  stall_pat = 4'b1001;
   int          stall_ph = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
   endtask

   function automatic logic [15:0] exp_count();
`ifdef ORDER_MSG_ENCODER_CNT_EN
      return 16'(msgs_done);
`else
      return 16'd0;
`endif
   endfunction

   task automatic push_msg();
      for (int i = 0; i < 9; i++) exp_q.push_back({4'(i), (i == 8), wv[i]});
   endtask

   task automatic issue(input logic [1:0] ty, input logic [1:0] sym, input logic [31:0] oid,
                        input logic [31:0] price, input logic [31:0] qty, input logic tr,
                        input logic [47:0] tm, input logic [15:0] loc, input logic [15:0] trk);
      logic ok;
      @(negedge i_clk);
      i_order_type = ty; i_stock_symbol = sym; i_order_id = oid; i_price = price;
      i_quantity = qty; i_trade_type = tr; i_curr_time = tm; i_locate_code = loc;
      i_tracking_number = trk; i_valid = 1'b1;
      ok = 1'b0;
      for (int k = 0; k < 50; k++) begin
         if (o_ready) begin ok = 1'b1; break; end
         @(negedge i_clk);
      end
      chk("accept", {63'b0, ok}, 64'd1);
      @(posedge i_clk);
      #1;
      // Scramble the fields after capture; the message must not change.
      i_valid = 1'b0;
      i_order_type = 2'($urandom); i_stock_symbol = 2'($urandom); i_order_id = $urandom;
      i_price = $urandom; i_quantity = $urandom; i_trade_type = 1'($urandom);
      i_curr_time = {16'($urandom), $urandom}; i_locate_code = 16'($urandom);
      i_tracking_number = 16'($urandom);
   endtask

   task automatic wait_done();
      logic done;
      done = 1'b0;
      for (int k = 0; k < 200; k++) begin
         @(negedge i_clk);
         if (exp_q.size() == 0 && o_ready) begin done = 1'b1; break; end
      end
      chk("msg_done", {63'b0, done}, 64'd1);
      if (done) msgs_done++;
   endtask

   initial begin
      forever begin
         @(posedge i_clk);
         #1;
         if (stall_mode) begin
            i_word_ready = stall_pat[3 - stall_ph];
            stall_ph = (stall_ph + 1) % 4;
         end else begin
            i_word_ready = 1'b1;
         end
      end
   end

   // Monitor: pops the scoreboard on every accepted beat and checks stability while stalled.
   initial begin
      logic        hold_vld;
      logic [31:0] hold_word;
      logic [3:0]  hold_idx;
      logic [36:0] e;
      hold_vld = 1'b0; hold_word = '0; hold_idx = '0;
      forever begin
         @(negedge i_clk);
         if (!i_rst_n) begin
            hold_vld = 1'b0;
         end else begin
            if (hold_vld)
               chk("stall_hold", {27'b0, o_word_valid, o_word_idx, o_word}, {27'b0, 1'b1, hold_idx, hold_word});
            if (o_word_valid) begin
               chk("ready_low_in_send", {63'b0, o_ready}, 64'd0);
               if (i_word_ready) begin
                  if (exp_q.size() == 0) begin
                     chk_cnt++;
                     $display("FAIL extra_beat: got idx %0d word 0x%0h, want no beat", o_word_idx, o_word);
                  end else begin
                     e = exp_q.pop_front();
                     chk("beat", {27'b0, o_word_idx, o_last, o_word}, {27'b0, e});
                  end
               end
            end else begin
               chk("idle_word_zero", {31'b0, o_last, o_word}, 64'd0);
            end
            hold_vld  = o_word_valid && !i_word_ready;
            hold_word = o_word;
            hold_idx  = o_word_idx;
         end
      end
   end

   initial begin
      logic hit;
      repeat (3) @(posedge i_clk);
      #1;
      chk("rst_outputs", {o_word_valid, o_word, o_word_idx, o_last, o_err, o_msg_count},
          {1'b0, 32'd0, 4'd0, 1'b0, 1'b0, 16'd0});
      @(negedge i_clk);
      i_rst_n = 1'b1;
      @(negedge i_clk);
      chk("rst_ready", {63'b0, o_ready}, 64'd1);

      // ADD AAPL SELL
      wv = '{32'h04010241, 32'h00000103, 32'h12000000, 32'h00000000, 32'h01000000,
             32'h0000000A, 32'h20202020, 32'h4141504C, 32'h00000064};
      push_msg();
      issue(2'd0, 2'd0, 32'h12, 32'h64, 32'h0A, 1'b1, 48'h1, 16'h0102, 16'h0304);
      wait_done();

      // CANCEL MSFT
      wv = '{32'h00000058, 32'h0, 32'h05000000, 32'h0, 32'h20000000,
             32'h54202020, 32'h004D5346, 32'h0, 32'h0};
      push_msg();
      issue(2'd1, 2'd3, 32'h5, 32'h0, 32'h0, 1'b0, 48'h0, 16'h0, 16'h0);
      wait_done();

      // EXECUTE GOOGL
      wv = '{32'h00000045, 32'h0, 32'h0, 32'h0, 32'h44000000,
             32'h20112233, 32'h474C2020, 32'h00474F4F, 32'h0};
      push_msg();
      issue(2'd2, 2'd2, 32'h0, 32'h0, 32'h11223344, 1'b0, 48'h0, 16'h0, 16'h0);
      wait_done();

      // ADD GOOGL BUY with every common field populated
      wv = '{32'h78123441, 32'hDDEEFF56, 32'hEFAABBCC, 32'h00DEADBE, 32'h00000000,
             32'h22222222, 32'h4C202020, 32'h474F4F47, 32'h11111111};
      push_msg();
      issue(2'd0, 2'd2, 32'hDEADBEEF, 32'h11111111, 32'h22222222, 1'b0,
            48'hAABBCCDDEEFF, 16'h1234, 16'h5678);
      wait_done();

      // ADD AAPL again under a 1,0,0,1 ready pattern
      stall_ph = 0;
      stall_mode = 1'b1;
      wv = '{32'h04010241, 32'h00000103, 32'h12000000, 32'h00000000, 32'h01000000,
             32'h0000000A, 32'h20202020, 32'h4141504C, 32'h00000064};
      push_msg();
      issue(2'd0, 2'd0, 32'h12, 32'h64, 32'h0A, 1'b1, 48'h1, 16'h0102, 16'h0304);
      wait_done();
      stall_mode = 1'b0;
      chk("count_after_msgs", {48'b0, o_msg_count}, {48'b0, exp_count()});

      // Illegal type: one-cycle error pulse, no words
      issue(2'd3, 2'd1, 32'h7, 32'h7, 32'h7, 1'b0, 48'h7, 16'h7, 16'h7);
      chk("err_pulse", {61'b0, o_err, o_word_valid, o_ready}, {61'b0, 1'b1, 1'b0, 1'b1});
      @(posedge i_clk);
      #1;
      chk("err_clear", {62'b0, o_err, o_word_valid}, 64'd0);
      repeat (3) @(negedge i_clk);

      // Reset while beat 4 of an ADD is on the bus
      wv = '{32'h04010241, 32'h00000103, 32'h12000000, 32'h00000000, 32'h01000000,
             32'h0000000A, 32'h20202020, 32'h4141504C, 32'h00000064};
      push_msg();
      issue(2'd0, 2'd0, 32'h12, 32'h64, 32'h0A, 1'b1, 48'h1, 16'h0102, 16'h0304);
      hit = 1'b0;
      for (int k = 0; k < 40; k++) begin
         if (o_word_valid && o_word_idx == 4'd4) begin hit = 1'b1; break; end
         @(posedge i_clk);
         #1;
      end
      chk("reach_beat4", {63'b0, hit}, 64'd1);
      i_rst_n = 1'b0;
      #1;
      exp_q.delete();
      msgs_done = 0;
      chk("abort_outputs", {o_word_valid, o_word, o_word_idx, o_last, o_msg_count},
          {1'b0, 32'd0, 4'd0, 1'b0, 16'd0});
      repeat (2) @(negedge i_clk);
      i_rst_n = 1'b1;
      @(negedge i_clk);
      chk("abort_ready", {63'b0, o_ready}, 64'd1);

      // Recovery message after the abort
      wv = '{32'h00000045, 32'h0, 32'h0, 32'h0, 32'h44000000,
             32'h20112233, 32'h474C2020, 32'h00474F4F, 32'h0};
      push_msg();
      issue(2'd2, 2'd2, 32'h0, 32'h0, 32'h11223344, 1'b0, 48'h0, 16'h0, 16'h0);
      wait_done();
      chk("count_after_abort", {48'b0, o_msg_count}, {48'b0, exp_count()});

      repeat (2) @(negedge i_clk);
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish, want finish before 200000");
      $fatal(1);
   end

endmodule
